// File: rtl/sd_init_sequencer_if.sv
// sd_init_sequencer_if: system-side status and sd_controller command/response signals
// of the SD initialisation sequencer; master is the sequencer, slave its environment.
interface sd_init_sequencer_if #(parameter int AW = 4);
    logic          init_start;
    logic          busy;
    logic          init_done;
    logic          init_error;
    logic [2:0]    error_code;
    logic          card_v2;
    logic          card_hc;
    logic [5:0]    sd_cmd;
    logic [31:0]   sd_arg;
    logic [6:0]    sd_crc;
    logic [AW-1:0] sd_nresponse;
    logic          sd_start;
    logic          sd_done;
    logic          resp_wr;
    logic [AW-1:0] resp_addr;
    logic [7:0]    resp_data;

    modport master (
        input  init_start, sd_done, resp_wr, resp_addr, resp_data,
        output busy, init_done, init_error, error_code, card_v2, card_hc,
               sd_cmd, sd_arg, sd_crc, sd_nresponse, sd_start
    );
    modport slave (
        output init_start, sd_done, resp_wr, resp_addr, resp_data,
        input  busy, init_done, init_error, error_code, card_v2, card_hc,
               sd_cmd, sd_arg, sd_crc, sd_nresponse, sd_start
    );
endinterface

// File: rtl/sd_init_sequencer.sv
// sd_init_sequencer: SPI-mode SD power-up sequencer (CMD0, CMD8, CMD55/ACMD41, CMD58)
// driving sd_controller and reporting card version/capacity or a coded error.
module sd_init_sequencer #(
    parameter int MEMORY_SIZE_IN_BYTES = 10,
    parameter int CMD0_RETRIES         = 8,
    parameter int ACMD41_RETRIES       = 1000
) (
    input logic               clk,
    input logic               rst,
    sd_init_sequencer_if.master bus
);
    localparam int AW = $clog2(MEMORY_SIZE_IN_BYTES);
    localparam logic [15:0] L_C0  = 16'(CMD0_RETRIES);
    localparam logic [15:0] L_A41 = 16'(ACMD41_RETRIES);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EVAL  = 3'd3;
    localparam logic [2:0] S_READY = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;
    localparam logic [2:0] C_CMD0   = 3'd0;
    localparam logic [2:0] C_CMD8   = 3'd1;
    localparam logic [2:0] C_CMD55  = 3'd2;
    localparam logic [2:0] C_ACMD41 = 3'd3;
    localparam logic [2:0] C_CMD58  = 3'd4;

    logic [2:0]    r_state, r_cur, r_err;
    logic [15:0]   r_cnt0, r_cnt41;
    logic          r_v2, r_hc;
    logic [7:0]    r_rb [5];
    logic [5:0]    r_cmd;
    logic [31:0]   r_arg;
    logic [6:0]    r_crc;
    logic [AW-1:0] r_nresp;

    logic [2:0]    w_nstate, w_ncur, w_nerr;
    logic [15:0]   w_ncnt0, w_ncnt41, w_inc41;
    logic          w_nv2, w_nhc, w_echo;
    logic [7:0]    w_r1;
    logic [5:0]    w_cmd;
    logic [31:0]   w_arg;
    logic [6:0]    w_crc;
    logic [AW-1:0] w_nresp;

    always_comb begin
        w_nstate = r_state;
        w_ncur   = r_cur;
        w_ncnt0  = r_cnt0;
        w_ncnt41 = r_cnt41;
        w_nv2    = r_v2;
        w_nhc    = r_hc;
        w_nerr   = r_err;
        w_r1     = r_rb[0];
        w_echo   = (r_rb[3] == 8'h01) && (r_rb[4] == 8'hAA);
        w_inc41  = (r_cnt41 == 16'hFFFF) ? r_cnt41 : r_cnt41 + 16'd1;
        case (r_state)
            S_ISSUE: w_nstate = S_WAIT;
            S_WAIT:  w_nstate = bus.sd_done ? S_EVAL : S_WAIT;
            S_EVAL: begin
                // r_err is always 0 here, so a nonzero w_nerr alone selects ERROR
                case (r_cur)
                    C_CMD0: begin
                        w_ncur  = (w_r1 == 8'h01) ? C_CMD8 : C_CMD0;
                        w_ncnt0 = r_cnt0 + 16'd1;
                        w_nerr  = (w_r1 != 8'h01 && r_cnt0 + 16'd1 >= L_C0) ? 3'd1 : 3'd0;
                    end
                    C_CMD8: begin
                        w_ncur = C_CMD55;
                        w_nv2  = (w_r1 == 8'h01) && w_echo;
                        w_nerr = (w_r1 == 8'h01) ? (w_echo ? 3'd0 : 3'd2) : (w_r1[2] ? 3'd0 : 3'd3);
                    end
                    C_CMD55: begin
                        w_ncur = C_ACMD41;
                        w_nerr = (w_r1 > 8'h01) ? 3'd7 : 3'd0;
                    end
                    C_ACMD41: begin
                        w_ncur   = (w_r1 == 8'h00) ? C_CMD58 : C_CMD55;
                        w_ncnt41 = (w_r1 == 8'h01) ? w_inc41 : r_cnt41;
                        w_nerr   = (w_r1 == 8'h01) ? ((w_inc41 < L_A41) ? 3'd0 : 3'd4) :
                                   ((w_r1 == 8'h00) ? 3'd0 : 3'd5);
                    end
                    default: begin
                        w_nhc  = (w_r1 == 8'h00) ? r_rb[1][6] : r_hc;
                        w_nerr = (w_r1 == 8'h00) ? 3'd0 : 3'd6;
                    end
                endcase
                w_nstate = (w_nerr != 3'd0) ? S_ERROR : ((r_cur == C_CMD58) ? S_READY : S_ISSUE);
            end
            default: if (bus.init_start) begin
                w_nstate = S_ISSUE;
                w_ncur   = C_CMD0;
                w_ncnt0  = 16'd0;
                w_ncnt41 = 16'd0;
                w_nv2    = 1'b0;
                w_nhc    = 1'b0;
                w_nerr   = 3'd0;
            end
        endcase
    end

    always_comb begin
        w_cmd   = 6'd0;
        w_arg   = 32'd0;
        w_crc   = 7'h4A;
        w_nresp = AW'(1);
        case (w_ncur)
            C_CMD8:   begin w_cmd = 6'd8;  w_arg = 32'h0000_01AA; w_crc = 7'h43; w_nresp = AW'(5); end
            C_CMD55:  begin w_cmd = 6'd55; w_crc = 7'h32; end
            C_ACMD41: begin w_cmd = 6'd41; w_arg = w_nv2 ? 32'h4000_0000 : 32'd0; w_crc = 7'h3B; end
            C_CMD58:  begin w_cmd = 6'd58; w_crc = 7'h7E; w_nresp = AW'(5); end
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cur   <= C_CMD0;
            r_err   <= 3'd0;
            r_cnt0  <= 16'd0;
            r_cnt41 <= 16'd0;
            r_v2    <= 1'b0;
            r_hc    <= 1'b0;
            r_rb    <= '{default: 8'h00};
            r_cmd   <= 6'd0;
            r_arg   <= 32'd0;
            r_crc   <= 7'd0;
            r_nresp <= '0;
        end else begin
            r_state <= w_nstate;
            r_cur   <= w_ncur;
            r_err   <= w_nerr;
            r_cnt0  <= w_ncnt0;
            r_cnt41 <= w_ncnt41;
            r_v2    <= w_nv2;
            r_hc    <= w_nhc;
            if (bus.resp_wr && bus.resp_addr < AW'(5))
                r_rb[bus.resp_addr[2:0]] <= bus.resp_data;
            // command fields load on entry to ISSUE and hold through WAIT/EVAL
            if (w_nstate == S_ISSUE) begin
                r_cmd   <= w_cmd;
                r_arg   <= w_arg;
                r_crc   <= w_crc;
                r_nresp <= w_nresp;
            end else if (w_nstate != S_WAIT && w_nstate != S_EVAL) begin
                r_cmd   <= 6'd0;
                r_arg   <= 32'd0;
                r_crc   <= 7'd0;
                r_nresp <= '0;
            end
        end
    end

    assign bus.busy         = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_EVAL);
    assign bus.init_done    = (r_state == S_READY);
    assign bus.init_error   = (r_state == S_ERROR);
    assign bus.error_code   = r_err;
    assign bus.card_v2      = r_v2;
    assign bus.card_hc      = r_hc;
    assign bus.sd_start     = (r_state == S_ISSUE);
    assign bus.sd_cmd       = r_cmd;
    assign bus.sd_arg       = r_arg;
    assign bus.sd_crc       = r_crc;
    assign bus.sd_nresponse = r_nresp;
endmodule
